// File: rtl/seg7_count_checker_pkg.sv
// Shared constants for the 7-segment count checker: segment patterns and FSM encodings.
package seg7_count_checker_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 3;
  localparam int unsigned RUN_W   = 4;

  // Active-high segment patterns {g,f,e,d,c,b,a} for digits 0..7
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;

  // Checker FSM encodings
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder: pattern + polarity -> {valid, digit}.
module seg7_decode
  import seg7_count_checker_pkg::*;
(
  input  logic [SEG_W-1:0]   display,
  input  logic               active_low,
  output logic               valid_c,
  output logic [DIGIT_W-1:0] digit_c
);

  logic [SEG_W-1:0] seg_ah;

  // Normalise to active-high, then match against the known digit patterns
  always_comb begin
    seg_ah  = active_low ? ~display : display;
    valid_c = 1'b1;
    digit_c = '0;
    case (seg_ah)
      SEG_0:   digit_c = 3'd0;
      SEG_1:   digit_c = 3'd1;
      SEG_2:   digit_c = 3'd2;
      SEG_3:   digit_c = 3'd3;
      SEG_4:   digit_c = 3'd4;
      SEG_5:   digit_c = 3'd5;
      SEG_6:   digit_c = 3'd6;
      SEG_7:   digit_c = 3'd7;
      default: valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_count_checker.sv
// Receive-side monitor for a 3-bit counter and its 7-segment display.
// Optional build macro: SEG7_CHK_STICKY_EN (a failure while locked latches FAULT until rst).
module seg7_count_checker
  import seg7_count_checker_pkg::*;
#(
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned MODULUS        = 8,
  parameter int unsigned LOCK_CNT       = 2,
  parameter int unsigned ERR_W          = 8
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               iEn,
  input  logic [2:0]         iQ,
  input  logic [6:0]         iDisplay,
  output logic [2:0]         oDigit,
  output logic               oDigitValid,
  output logic               oLocked,
  output logic               oMismatch,
  output logic [ERR_W-1:0]   oErrCount
);

  logic               dec_valid_c;
  logic [DIGIT_W-1:0] dec_digit_c;
  logic               v_c, c_c, s_c, ok_c;
  logic [DIGIT_W-1:0] prev_inc_c;
  logic [RUN_W-1:0]   run_inc_c;
  logic [1:0]         state, state_nxt;
  logic [RUN_W-1:0]   run, run_nxt;
  logic [DIGIT_W-1:0] prev;
  logic               mismatch_c;

  seg7_decode u_decode (
    .display    (iDisplay),
    .active_low (1'(SEG_ACTIVE_LOW)),
    .valid_c    (dec_valid_c),
    .digit_c    (dec_digit_c)
  );

  // Per-sample checks: valid digit, coherent with iQ, and a legal +1 step
  always_comb begin
    v_c        = dec_valid_c && ({1'b0, dec_digit_c} < 4'(MODULUS));
    c_c        = v_c && (dec_digit_c == iQ);
    prev_inc_c = (prev == 3'(MODULUS - 1)) ? 3'd0 : prev + 3'd1;
    s_c        = (iQ == prev_inc_c);
    ok_c       = v_c && c_c && s_c;
    run_inc_c  = run + RUN_W'(1);
  end

  // Next-state logic for the lock FSM and run counter
  always_comb begin
    state_nxt  = state;
    run_nxt    = run;
    mismatch_c = 1'b0;
    if (iEn) begin
      case (state)
        ST_SEARCH: begin
          if (v_c && c_c) begin
            if (run == '0) begin
              run_nxt = RUN_W'(1);
            end else if (s_c) begin
              if (run_inc_c == RUN_W'(LOCK_CNT)) begin
                state_nxt = ST_LOCKED;
                run_nxt   = '0;
              end else begin
                run_nxt = run_inc_c;
              end
            end else begin
              run_nxt = RUN_W'(1);
            end
          end else begin
            run_nxt    = '0;
            mismatch_c = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!ok_c) begin
            mismatch_c = 1'b1;
            run_nxt    = '0;
`ifdef SEG7_CHK_STICKY_EN
            state_nxt  = ST_FAULT;
`else
            state_nxt  = ST_SEARCH;
`endif
          end
        end
        ST_FAULT: begin
          mismatch_c = !ok_c;
        end
        default: begin
          state_nxt = ST_SEARCH;
          run_nxt   = '0;
        end
      endcase
    end
  end

  // State, history and registered outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= ST_SEARCH;
      run         <= '0;
      prev        <= '0;
      oDigit      <= '0;
      oDigitValid <= 1'b0;
      oLocked     <= 1'b0;
      oMismatch   <= 1'b0;
      oErrCount   <= '0;
    end else begin
      state     <= state_nxt;
      run       <= run_nxt;
      oLocked   <= (state_nxt == ST_LOCKED);
      oMismatch <= mismatch_c;
      if (iEn) begin
        prev        <= iQ;
        oDigit      <= v_c ? dec_digit_c : 3'd0;
        oDigitValid <= v_c;
      end
      if (mismatch_c && (oErrCount != '1)) begin
        oErrCount <= oErrCount + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg7_count_checker.sv
// Directed self-checking bench for seg7_count_checker (default, ERR_W=2, and MODULUS=6 instances).
module tb_seg7_count_checker;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       iEn = 1'b0;
  logic [2:0] iQ = 3'd0;
  logic [6:0] iDisplay = 7'h7F;

  logic [2:0] dig_a, dig_b, dig_c;
  logic       dv_a, dv_b, dv_c;
  logic       lk_a, lk_b, lk_c;
  logic       mm_a, mm_b, mm_c;
  logic [7:0] ec_a;
  logic [1:0] ec_b;
  logic [7:0] ec_c;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  seg7_count_checker dut (
    .CLK(CLK), .rst(rst), .iEn(iEn), .iQ(iQ), .iDisplay(iDisplay),
    .oDigit(dig_a), .oDigitValid(dv_a), .oLocked(lk_a), .oMismatch(mm_a), .oErrCount(ec_a)
  );

  seg7_count_checker #(.ERR_W(2)) dut_sat (
    .CLK(CLK), .rst(rst), .iEn(iEn), .iQ(iQ), .iDisplay(iDisplay),
    .oDigit(dig_b), .oDigitValid(dv_b), .oLocked(lk_b), .oMismatch(mm_b), .oErrCount(ec_b)
  );

  seg7_count_checker #(.MODULUS(6), .LOCK_CNT(3)) dut_m6 (
    .CLK(CLK), .rst(rst), .iEn(iEn), .iQ(iQ), .iDisplay(iDisplay),
    .oDigit(dig_c), .oDigitValid(dv_c), .oLocked(lk_c), .oMismatch(mm_c), .oErrCount(ec_c)
  );

  // Active-low patterns, hand-inverted from the active-high table
  function automatic logic [6:0] al(input int d);
    case (d)
      0: al = 7'h40;
      1: al = 7'h79;
      2: al = 7'h24;
      3: al = 7'h30;
      4: al = 7'h19;
      5: al = 7'h12;
      6: al = 7'h02;
      default: al = 7'h78;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int d, input int dv, input int lk,
                       input int mm, input int ec);
    chk({tag, ".digit"}, int'(dig_a), d);
    chk({tag, ".valid"}, int'(dv_a), dv);
    chk({tag, ".locked"}, int'(lk_a), lk);
    chk({tag, ".mismatch"}, int'(mm_a), mm);
    chk({tag, ".errcnt"}, int'(ec_a), ec);
  endtask

  task automatic step(input logic en, input logic [2:0] q, input logic [6:0] d);
    iEn = en;
    iQ = q;
    iDisplay = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step(1'b1, 3'd5, 7'h55);
    rst = 1'b0;
  endtask

  initial begin
    // T1: reset with junk inputs, first sample afterwards counts as run=1
    rst = 1'b1;
    step(1'b1, 3'd3, 7'h55);
    step(1'b1, 3'd6, 7'h12);
    chk_a("t1_rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1'b1, 3'd5, al(5));
    chk_a("t1_first", 5, 1, 0, 0, 0);
    step(1'b1, 3'd6, al(6));
    chk_a("t1_second", 6, 1, 1, 0, 0);

    // T2: clean 0..7,0,1 sequence with wrap
    do_rst();
    step(1'b1, 3'd0, al(0));
    chk_a("t2_s0", 0, 1, 0, 0, 0);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 3'(i % 8), al(i % 8));
      chk_a($sformatf("t2_s%0d", i), i % 8, 1, 1, 0, 0);
    end

    // T3: incoherent sample while locked (iQ=3, display shows 5)
    step(1'b1, 3'd2, al(2));
    chk_a("t3_pre", 2, 1, 1, 0, 0);
    step(1'b1, 3'd3, 7'h12);
    chk_a("t3_bad", 5, 1, 0, 1, 1);
    step(1'b1, 3'd4, al(4));
    chk_a("t3_next", 4, 1, 0, 0, 1);
    step(1'b1, 3'd5, al(5));
`ifdef SEG7_CHK_STICKY_EN
    chk_a("t3_relock", 5, 1, 0, 0, 1);
`else
    chk_a("t3_relock", 5, 1, 1, 0, 1);
`endif

    // T4: coherent but skipped step 4 -> 6 while locked
    do_rst();
    chk_a("t4_rst", 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 3'(i), al(i));
    chk_a("t4_locked4", 4, 1, 1, 0, 0);
    step(1'b1, 3'd6, 7'h02);
    chk_a("t4_skip", 6, 1, 0, 1, 1);

    // T5: blank display, saturation of a 2-bit counter, then idle clears the pulse
    do_rst();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 3'd0, 7'h7F);
      chk_a($sformatf("t5_blank%0d", i), 0, 0, 0, 1, i);
      chk($sformatf("t5_sat%0d", i), int'(ec_b), (i > 3) ? 3 : i);
    end
    chk("t5_sat_mm", int'(mm_b), 1);
    step(1'b0, 3'd0, 7'h7F);
    chk_a("t5_idle", 0, 0, 0, 0, 4);
    chk("t5_sat_idle", int'(ec_b), 3);

    // T6: iEn low with junk inputs while locked, then continue
    do_rst();
    for (int i = 0; i < 3; i++) step(1'b1, 3'(i), al(i));
    chk_a("t6_locked", 2, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'd7, 7'h7F);
      chk_a($sformatf("t6_hold%0d", i), 2, 1, 1, 0, 0);
    end
    step(1'b1, 3'd3, al(3));
    chk_a("t6_cont3", 3, 1, 1, 0, 0);
    step(1'b1, 3'd4, al(4));
    chk_a("t6_cont4", 4, 1, 1, 0, 0);
    rst = 1'b1;
    step(1'b1, 3'd5, al(5));
    chk_a("t6_rst_locked", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // T7: MODULUS=6, LOCK_CNT=3 instance: 5->0 wrap legal, digit 6 invalid
    step(1'b1, 3'd4, al(4));
    step(1'b1, 3'd5, al(5));
    chk("t7_m6_run2_lock", int'(lk_c), 0);
    step(1'b1, 3'd0, al(0));
    chk("t7_m6_wrap_lock", int'(lk_c), 1);
    chk("t7_m6_wrap_mm", int'(mm_c), 0);
    step(1'b1, 3'd1, al(1));
    chk("t7_m6_s1_lock", int'(lk_c), 1);
    chk("t7_m6_s1_digit", int'(dig_c), 1);
    step(1'b1, 3'd6, al(6));
    chk("t7_m6_d6_mm", int'(mm_c), 1);
    chk("t7_m6_d6_valid", int'(dv_c), 0);
    chk("t7_m6_d6_digit", int'(dig_c), 0);
    chk("t7_m6_d6_lock", int'(lk_c), 0);
    chk("t7_m6_d6_err", int'(ec_c), 1);
    chk("t7_dflt_d6_digit", int'(dig_a), 6);
    chk("t7_sat_d6_valid", int'(dv_b), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
